// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: ps2clk edge filter, 11-bit framer, E0/F0 prefix
// decoder and an event FIFO with a valid/ready consumer interface.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_kbd_rx_fifo #(
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] code_data,
  output logic       code_ext,
  output logic       code_brk,
  output logic       code_valid,
  input  logic       code_ready,
  output logic       err_parity,
  output logic       err_ovf,
  output logic       err_timeout
);

  localparam int unsigned SAMP_W = 2 * FILT_LEN;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = 10;
  localparam logic [7:0]  BYTE_EXT = 8'hE0;
  localparam logic [7:0]  BYTE_BRK = 8'hF0;

  logic [SAMP_W-1:0] r_samp;
  logic [3:0]        r_bitcnt;
  logic [9:0]        r_shift;
  logic              r_done;
  logic              r_good;
  logic [7:0]        r_byte;
  logic              r_ext;
  logic              r_brk;
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;
  logic [CNT_W-1:0]  r_count;

  logic w_fall;
  logic w_timeout;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_wr;

  // Qualified falling edge: FILT_LEN stable highs followed by FILT_LEN stable lows
  assign w_fall = (r_samp[SAMP_W-1:FILT_LEN] == {FILT_LEN{1'b1}}) &&
                  (r_samp[FILT_LEN-1:0] == '0);

  // ps2clk sample history, oldest sample at the MSB
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_samp <= '0;
    else       r_samp <= {r_samp[SAMP_W-2:0], ps2clk};
  end

  // Framer: shift start/data/parity, judge the frame on the stop-bit edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitcnt <= 4'd0;
      r_shift  <= '0;
      r_done   <= 1'b0;
      r_good   <= 1'b0;
      r_byte   <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (w_timeout) begin
        r_bitcnt <= 4'd0;
      end else if (w_fall) begin
        if (r_bitcnt == 4'd10) begin
          r_bitcnt <= 4'd0;
          r_done   <= 1'b1;
          // r_shift[0]=start, [8:1]=data, [9]=parity; odd parity over data+parity
          r_good   <= ~r_shift[0] & ps2data & (^r_shift[9:1]);
          r_byte   <= r_shift[8:1];
        end else begin
          r_shift  <= {ps2data, r_shift[9:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wdog;

  // Watchdog: counts idle cycles inside a frame, restarted by every edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       r_wdog <= '0;
    else if ((r_bitcnt == 4'd0) || w_fall || w_timeout) r_wdog <= '0;
    else                                             r_wdog <= r_wdog + WD_W'(1);
  end

  assign w_timeout = (r_bitcnt != 4'd0) && !w_fall &&
                     (r_wdog == WD_W'(TIMEOUT_CYC - 1));
`else
  // No watchdog; the parameter only keeps the interface identical across builds
  assign w_timeout = 1'b0 && (TIMEOUT_CYC == 0);
`endif

  // Prefix bytes only update flags; every other good byte becomes an event
  assign w_push = r_done && r_good && (r_byte != BYTE_EXT) && (r_byte != BYTE_BRK);

  // Prefix flags: set by E0/F0, cleared on event, bad frame or timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_timeout || (r_done && !r_good)) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_done) begin
      if (r_byte == BYTE_EXT)      r_ext <= 1'b1;
      else if (r_byte == BYTE_BRK) r_brk <= 1'b1;
      else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign code_valid = (r_count != '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop      = code_valid && code_ready;
  // A push into a full FIFO survives only if the head leaves in the same cycle
  assign w_wr       = w_push && (!w_full || w_pop);

  // Event FIFO storage and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= {r_ext, r_brk, r_byte};
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) r_rd <= r_rd + PTR_W'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign code_ext  = r_mem[r_rd][9];
  assign code_brk  = r_mem[r_rd][8];
  assign code_data = r_mem[r_rd][7:0];

  // Error pulses; their sources never coincide in one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_parity  <= 1'b0;
      err_ovf     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_parity  <= r_done && !r_good;
      err_ovf     <= w_push && w_full && !w_pop;
      err_timeout <= w_timeout;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Self-checking bench for ps2_kbd_rx_fifo: expected events are queued when a
// frame is sent and compared when the DUT hands them out.
module tb_ps2_kbd_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2clk;
  logic       ps2data;
  logic [7:0] code_data;
  logic       code_ext;
  logic       code_brk;
  logic       code_valid;
  logic       code_ready;
  logic       err_parity;
  logic       err_ovf;
  logic       err_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int n_par = 0, n_ovf = 0, n_to = 0;
  int e_par = 0, e_ovf = 0, e_to = 0;
  logic [9:0] exp_q [$];

  ps2_kbd_rx_fifo #(.FILT_LEN(4), .FIFO_DEPTH(4), .TIMEOUT_CYC(1000)) dut (
    .clk(clk), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
    .code_data(code_data), .code_ext(code_ext), .code_brk(code_brk),
    .code_valid(code_valid), .code_ready(code_ready),
    .err_parity(err_parity), .err_ovf(err_ovf), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    tick(1);
    ps2data = v;
    tick(5);
    ps2clk = 1'b0;
    tick(10);
    ps2clk = 1'b1;
    tick(5);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    tick(4);
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] b);
    exp_q.push_back({ext, brk, b});
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      tick(1);
      k++;
    end
    check_eq("drain_bound", 32'(exp_q.size()), 32'd0);
    tick(2);
  endtask

  task automatic check_errs(input string tag);
    check_eq({tag, "_npar"}, 32'(n_par), 32'(e_par));
    check_eq({tag, "_novf"}, 32'(n_ovf), 32'(e_ovf));
    check_eq({tag, "_nto"},  32'(n_to),  32'(e_to));
  endtask

  // Consumer side: compare each accepted event and tally error pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (code_valid && code_ready) begin
        if (exp_q.size() == 0)
          check_eq("unexpected_evt", {22'd0, code_ext, code_brk, code_data}, 32'h3ff);
        else
          check_eq("event", {22'd0, code_ext, code_brk, code_data}, {22'd0, exp_q.pop_front()});
      end
      if (err_parity)  n_par++;
      if (err_ovf)     n_ovf++;
      if (err_timeout) n_to++;
      if (err_parity || err_ovf || err_timeout)
        check_eq("err_excl", 32'(err_parity) + 32'(err_ovf) + 32'(err_timeout), 32'd1);
    end
  end

  initial begin
    reset = 1'b1; ps2clk = 1'b1; ps2data = 1'b1; code_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(code_valid), 32'd0);
    check_eq("rst_data",  32'(code_data), 32'd0);
    check_eq("rst_flags", {30'd0, code_ext, code_brk}, 32'd0);
    check_eq("rst_errs",  {29'd0, err_parity, err_ovf, err_timeout}, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(20);

    // Plain make code
    expect_evt(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0);
    wait_drain();
    check_errs("make");

    // Break: F0 alone makes no event, F0 1C makes one break event
    send_frame(8'hF0, 1'b0);
    tick(10);
    check_eq("f0_no_evt", 32'(code_valid), 32'd0);
    expect_evt(1'b0, 1'b1, 8'h1C);
    send_frame(8'h1C, 1'b0);
    wait_drain();

    // Extended break then a plain make clears the prefixes
    expect_evt(1'b1, 1'b1, 8'h75);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    expect_evt(1'b0, 1'b0, 8'h75);
    send_frame(8'h75, 1'b0);
    wait_drain();
    expect_evt(1'b1, 1'b0, 8'h6B);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h6B, 1'b0);
    wait_drain();
    check_errs("decode");

    // Parity errors; a bad frame also clears a pending E0
    send_frame(8'h1C, 1'b1);
    e_par++;
    tick(10);
    check_eq("par_no_evt", 32'(code_valid), 32'd0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h55, 1'b1);
    e_par++;
    expect_evt(1'b0, 1'b0, 8'h6B);
    send_frame(8'h6B, 1'b0);
    wait_drain();
    check_errs("parity");

    // Overflow: fifth event dropped while ready is low, then in-order drain
    code_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) expect_evt(1'b0, 1'b0, 8'(i));
      send_frame(8'(i), 1'b0);
    end
    e_ovf++;
    tick(5);
    check_eq("ovf_valid", 32'(code_valid), 32'd1);
    check_eq("ovf_head",  32'(code_data), 32'h01);
    tick(7);
    check_eq("ovf_head_hold", 32'(code_data), 32'h01);
    check_errs("ovf");
    code_ready = 1'b1;
    wait_drain();
    check_eq("ovf_empty", 32'(code_valid), 32'd0);

`ifdef PS2_RX_TIMEOUT_EN
    // Partial frame aborted by the watchdog, next frame still decodes
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    tick(1100);
    e_to++;
    check_errs("timeout");
    expect_evt(1'b0, 1'b0, 8'h29);
    send_frame(8'h29, 1'b0);
    wait_drain();
`endif

    // Reset mid-frame with a queued event discards everything
    code_ready = 1'b0;
    send_frame(8'h33, 1'b0);
    tick(2);
    check_eq("pre_rst_valid", 32'(code_valid), 32'd1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_rst_valid", 32'(code_valid), 32'd0);
    check_eq("mid_rst_out", {19'd0, code_data, code_ext, code_brk, err_parity, err_ovf, err_timeout}, 32'd0);
    tick(1);
    reset = 1'b0;
    code_ready = 1'b1;
    tick(10);
    expect_evt(1'b0, 1'b0, 8'h29);
    send_frame(8'h29, 1'b0);
    wait_drain();
    check_errs("final");
    check_eq("final_empty", 32'(code_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
